xgmii_tx_framer: RTL
====================

XGMII_TX_FRAMER -- requirements
Module: xgmii_tx_framer

Interface
REQ-001 Param IFG_WORDS, default 1, minimum count of all-idle words emitted after each frame's terminate word (range 0..15).
REQ-002 sys_clk  in  1  single clock; FIFO read side and XGMII TX both run on it.
REQ-003 sys_rst  in  1  reset, synchronous and active-high.
REQ-004 dout  in  72  FWFT FIFO head word, {txc[7:0], txd[63:0]}; valid whenever empty=0.
REQ-005 empty  in  1  FIFO empty flag.
REQ-006 rd_en  out  1  pops the head word this cycle; never asserted while empty=1.
REQ-007 xgmii_txd  out  64  XGMII TX data, registered.
REQ-008 xgmii_txc  out  8  XGMII TX control, registered.

Function
REQ-009 Codes SHALL be: idle lane = d 8'h07 with c=1; start = lane0 d 8'hFB with c=1; terminate = any lane d 8'hFD with c=1; error = d 8'hFE with c=1.
REQ-010 IDLE_WORD SHALL be txc=8'hFF, txd=64'h0707070707070707.
REQ-011 Head-to-output latency SHALL be exactly 1 cycle: a word popped in cycle N appears on xgmii_* in cycle N+1.
REQ-012 FSM states SHALL be IDLE, DATA, FLUSH, GAP.
REQ-013 IDLE: empty=1 -> emit IDLE_WORD, no pop.
REQ-014 IDLE: head is start word -> pop, emit it unchanged, go DATA.
REQ-015 IDLE: head not start -> pop, discard, emit IDLE_WORD, increment drop count; stay IDLE.
REQ-016 DATA: empty=0 -> pop, emit unchanged; if the word contains terminate -> GAP (IDLE if IFG_WORDS=0), increment frame count.
REQ-017 DATA: empty=1 (underrun) -> no pop, emit ERR_WORD (txc=8'hFF, lane0 8'hFE, lane1 8'hFD, lanes2-7 8'h07), increment underrun count, go FLUSH.
REQ-018 FLUSH: pop and discard every available word, emitting IDLE_WORD, until a word containing terminate is popped -> GAP (IDLE if IFG_WORDS=0).
REQ-019 FLUSH: start word seen before any terminate -> do not pop it, go GAP/IDLE (broken frame ends there).
REQ-020 GAP: emit IDLE_WORD, no pop, for exactly IFG_WORDS cycles, then IDLE; gap counter 4 bits.
REQ-021 Terminate and start in the same head word while in DATA -> treat as terminate only; the start is not honoured.
REQ-022 Output payload SHALL never be modified except as in REQ-017.

Reset
REQ-023 While sys_rst=1: state IDLE, rd_en=0, gap counter 0, xgmii_* = IDLE_WORD on the following edge.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no ERR_WORD; the remainder is then discarded via REQ-015.

Configuration
REQ-025 Macro XGMII_TX_STATS_EN SHALL add outputs tx_frames[31:0], tx_underruns[15:0], tx_drops[15:0].
REQ-026 With XGMII_TX_STATS_EN: counters reset to 0, increment per REQ-015/016/017, and wrap modulo 2^width.
REQ-027 Without XGMII_TX_STATS_EN: these ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-028 Package xgmii_pkg SHALL hold the code constants, IDLE_WORD, ERR_WORD and the FSM state enum.
REQ-029 Sub-module xgmii_ctrl_scan SHALL be combinational: 72-bit word in -> is_start, has_term out; instantiated once, on dout.

Verification
REQ-030 Three-word frame (FB start, data, FD in lane 3) with IFG_WORDS=1 -> the same three words on cycles N+1..N+3, then exactly one IDLE_WORD before the next start.
REQ-031 Back-to-back frames in the FIFO with IFG_WORDS=3 -> exactly 3 IDLE_WORDs between the first frame's terminate word and the second frame's start word.
REQ-032 empty rises after the start word and one data word -> ERR_WORD on the next output cycle; the remaining words up to FD are discarded; tx_underruns=1.
REQ-033 Two leading non-start data words then a frame -> 2 IDLE_WORDs, then the frame; tx_drops=2.
REQ-034 sys_rst pulsed for 1 cycle mid-frame -> next output is IDLE_WORD, rd_en=0 during reset, no ERR_WORD; the leftover frame is dropped.
REQ-035 rd_en SHALL never be high while empty=1 across randomized empty toggling (assertion).

Source files
------------

// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - XGMII control codes, fixed idle/error words and TX framer state encoding
package xgmii_pkg;

  localparam logic [7:0] C_IDLE  = 8'h07;
  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_ERR   = 8'hFE;

  // Words are {txc[7:0], txd[63:0]}; lane 0 occupies txd[7:0]
  localparam logic [71:0] IDLE_WORD = {8'hFF, {8{C_IDLE}}};
  localparam logic [71:0] ERR_WORD  = {8'hFF, {6{C_IDLE}}, C_TERM, C_ERR};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_FLUSH,
    ST_GAP
  } tx_state_e;

endpackage

// File: rtl/xgmii_ctrl_scan.sv
// rtl/xgmii_ctrl_scan.sv - combinational start/terminate detection on one 72-bit XGMII word
module xgmii_ctrl_scan
  import xgmii_pkg::*;
(
  input  logic [71:0] word,
  output logic        is_start,
  output logic        has_term
);

  always_comb begin
    is_start = word[64] && (word[7:0] == C_START);
    has_term = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (word[64+i] && (word[8*i +: 8] == C_TERM)) begin
        has_term = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xgmii_tx_framer.sv
// rtl/xgmii_tx_framer.sv - FWFT FIFO to XGMII TX framer with inter-frame gap and underrun handling
// Optional frame/underrun/drop counters are built when XGMII_TX_STATS_EN is defined.
module xgmii_tx_framer
  import xgmii_pkg::*;
#(
  parameter int IFG_WORDS = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [71:0] dout,
  input  logic        empty,
  output logic        rd_en,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc
`ifdef XGMII_TX_STATS_EN
  ,
  output logic [31:0] tx_frames,
  output logic [15:0] tx_underruns,
  output logic [15:0] tx_drops
`endif
);

  localparam tx_state_e  END_STATE = (IFG_WORDS == 0) ? ST_IDLE : ST_GAP;
  localparam logic [3:0] GAP_LAST  = 4'((IFG_WORDS == 0) ? 0 : IFG_WORDS - 1);

  tx_state_e   state_q, state_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [71:0] word_q, word_d;
  logic        pop;
  logic        is_start, has_term;

  xgmii_ctrl_scan u_scan (
    .word     (dout),
    .is_start (is_start),
    .has_term (has_term)
  );

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    word_d    = IDLE_WORD;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (is_start) begin
            word_d  = dout;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (!empty) begin
          pop    = 1'b1;
          word_d = dout;
          if (has_term) begin
            state_d   = END_STATE;
            gap_cnt_d = 4'd0;
          end
        end else begin
          word_d  = ERR_WORD;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // A fresh start word closes the broken frame and is left for IDLE to take
        if (!empty) begin
          if (is_start) begin
            state_d   = END_STATE;
            gap_cnt_d = 4'd0;
          end else begin
            pop = 1'b1;
            if (has_term) begin
              state_d   = END_STATE;
              gap_cnt_d = 4'd0;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_en = pop && !sys_rst;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= 4'd0;
      word_q    <= IDLE_WORD;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      word_q    <= word_d;
    end
  end

  assign {xgmii_txc, xgmii_txd} = word_q;

`ifdef XGMII_TX_STATS_EN
  logic [31:0] tx_frames_q, tx_frames_d;
  logic [15:0] tx_underruns_q, tx_underruns_d;
  logic [15:0] tx_drops_q, tx_drops_d;

  always_comb begin
    tx_frames_d    = tx_frames_q + {31'd0, (state_q == ST_DATA) && !empty && has_term};
    tx_underruns_d = tx_underruns_q + {15'd0, (state_q == ST_DATA) && empty};
    tx_drops_d     = tx_drops_q + {15'd0, (state_q == ST_IDLE) && !empty && !is_start};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_frames_q    <= 32'd0;
      tx_underruns_q <= 16'd0;
      tx_drops_q     <= 16'd0;
    end else begin
      tx_frames_q    <= tx_frames_d;
      tx_underruns_q <= tx_underruns_d;
      tx_drops_q     <= tx_drops_d;
    end
  end

  assign tx_frames    = tx_frames_q;
  assign tx_underruns = tx_underruns_q;
  assign tx_drops     = tx_drops_q;
`endif

endmodule
